// File: rtl/sync_pkg.sv
// Shared constants and helpers for the multi-channel level synchroniser.
// The optional glitch filter is enabled by defining SYNC_FILTER_EN.
package sync_pkg;

  localparam int   SYNC_STAGES_MIN = 2;
  localparam logic SYNC_RESET_BIT  = 1'b0;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One synchroniser channel: flop chain, optional persistence filter, registered edge pulses.
// Filter present only when SYNC_FILTER_EN is defined.
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int   STAGES     = 2,
  parameter logic RESET_BIT  = SYNC_RESET_BIT,
  parameter int   FILTER_CNT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall,
  output logic o_edge_next
);

  if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("sync_filter_ch: STAGES must be at least 2");
  end
  if (FILTER_CNT < 1) begin : g_bad_filter
    $error("sync_filter_ch: FILTER_CNT must be at least 1");
  end

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_chain;
  logic r_rise;
  logic r_fall;
  logic w_raw;
  logic w_prev;
  logic w_level;
  logic w_rise_next;
  logic w_fall_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_chain <= {STAGES{RESET_BIT}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  assign w_raw  = r_chain[STAGES-1];
  assign w_prev = r_chain[STAGES-2];

`ifdef SYNC_FILTER_EN
  localparam int CNT_W = clog2(FILTER_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CNT - 1);

  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_level_next;
  logic [CNT_W-1:0] w_cnt_next;

  // The counter only advances while the raw level disagrees with the filtered one.
  always_comb begin
    w_level_next = r_level;
    w_cnt_next   = r_cnt;
    w_rise_next  = 1'b0;
    w_fall_next  = 1'b0;
    if (w_raw == r_level) begin
      w_cnt_next = '0;
    end else if (r_cnt == CNT_LAST) begin
      w_level_next = w_raw;
      w_cnt_next   = '0;
      w_rise_next  = w_raw;
      w_fall_next  = ~w_raw;
    end else begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_level <= RESET_BIT;
      r_cnt   <= '0;
    end else begin
      r_level <= w_level_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign w_level = r_level;
`else
  // Pulses are computed one stage early so they line up with the raw level update.
  assign w_rise_next = w_prev & ~w_raw;
  assign w_fall_next = ~w_prev & w_raw;
  assign w_level     = w_raw;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_rise_next;
      r_fall <= w_fall_next;
    end
  end

  assign o_sync      = w_level;
  assign o_rise      = r_rise;
  assign o_fall      = r_fall;
  assign o_edge_next = w_rise_next | w_fall_next;

endmodule

// File: rtl/multi_sync_edge.sv
// WIDTH independent level synchronisers with rise/fall pulses and a combined change flag.
// Define SYNC_FILTER_EN to add a FILTER_CNT-cycle persistence filter per channel.
module multi_sync_edge
  import sync_pkg::*;
#(
  parameter int               WIDTH      = 1,
  parameter int               STAGES     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{SYNC_RESET_BIT}},
  parameter int               FILTER_CNT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             change_o
);

  logic [WIDTH-1:0] w_edge_next;
  logic             r_change;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    sync_filter_ch #(
      .STAGES     (STAGES),
      .RESET_BIT  (RESET_VAL[gi]),
      .FILTER_CNT (FILTER_CNT)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_async     (async_i[gi]),
      .o_sync      (sync_o[gi]),
      .o_rise      (rise_o[gi]),
      .o_fall      (fall_o[gi]),
      .o_edge_next (w_edge_next[gi])
    );
  end

  // Built from next-state pulses so change_o asserts in the same cycle as rise_o/fall_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_change <= 1'b0;
    end else begin
      r_change <= |w_edge_next;
    end
  end

  assign change_o = r_change;

endmodule
